// File: rtl/mycpu_ex_commit.sv
// EX-to-MEM commit stage: registers the EX bundle under valid/allowin, squashes
// overflowing instructions, raises the Ov exception to CP0 and drives a timed flush.
module mycpu_ex_commit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [4:0]  EXC_CODE_OV  = 5'h0C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_allowin,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_result,
  input  logic [4:0]  ex_dest,
  input  logic        ex_wen,
  input  logic        ex_ov,
  input  logic        ex_bd,
  input  logic        wb_allowin,
  output logic        ms_valid,
  output logic [31:0] ms_pc,
  output logic [31:0] ms_result,
  output logic [4:0]  ms_dest,
  output logic        ms_wen,
  output logic        exc_req,
  output logic [31:0] exc_epc,
  output logic [4:0]  exc_code,
  output logic        exc_bd,
  output logic        flush,
  output logic [15:0] exc_count
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned EXCC_W = 16;

  localparam logic [0:0] S_NORMAL = 1'b0;
  localparam logic [0:0] S_FLUSH  = 1'b1;

  logic [0:0]        r_state,      w_state_nxt;
  logic [CNT_W-1:0]  r_flush_cnt,  w_flush_cnt_nxt;
  logic              r_ms_valid,   w_ms_valid_nxt;
  logic [XLEN-1:0]   r_ms_pc,      w_ms_pc_nxt;
  logic [XLEN-1:0]   r_ms_result,  w_ms_result_nxt;
  logic [4:0]        r_ms_dest,    w_ms_dest_nxt;
  logic              r_ms_wen,     w_ms_wen_nxt;
  logic              r_exc_req,    w_exc_req_nxt;
  logic [XLEN-1:0]   r_exc_epc,    w_exc_epc_nxt;
  logic [4:0]        r_exc_code,   w_exc_code_nxt;
  logic              r_exc_bd,     w_exc_bd_nxt;
  logic              r_flush,      w_flush_nxt;
  logic [EXCC_W-1:0] r_exc_count,  w_exc_count_nxt;

  logic w_allowin;
  logic w_accept;
  logic w_take_exc;

  // Only path from inputs to an output: state, occupancy and downstream readiness.
  assign w_allowin  = (r_state == S_NORMAL) && (!r_ms_valid || wb_allowin);
  assign w_accept   = ex_valid && w_allowin;
  assign w_take_exc = w_accept && ex_ov;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_NORMAL;
      r_flush_cnt <= '0;
      r_ms_valid  <= 1'b0;
      r_ms_pc     <= '0;
      r_ms_result <= '0;
      r_ms_dest   <= '0;
      r_ms_wen    <= 1'b0;
      r_exc_req   <= 1'b0;
      r_exc_epc   <= '0;
      r_exc_code  <= '0;
      r_exc_bd    <= 1'b0;
      r_flush     <= 1'b0;
      r_exc_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_ms_valid  <= w_ms_valid_nxt;
      r_ms_pc     <= w_ms_pc_nxt;
      r_ms_result <= w_ms_result_nxt;
      r_ms_dest   <= w_ms_dest_nxt;
      r_ms_wen    <= w_ms_wen_nxt;
      r_exc_req   <= w_exc_req_nxt;
      r_exc_epc   <= w_exc_epc_nxt;
      r_exc_code  <= w_exc_code_nxt;
      r_exc_bd    <= w_exc_bd_nxt;
      r_flush     <= w_flush_nxt;
      r_exc_count <= w_exc_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_ms_valid_nxt  = r_ms_valid;
    w_ms_pc_nxt     = r_ms_pc;
    w_ms_result_nxt = r_ms_result;
    w_ms_dest_nxt   = r_ms_dest;
    w_ms_wen_nxt    = r_ms_wen;
    w_exc_req_nxt   = 1'b0;
    w_exc_epc_nxt   = r_exc_epc;
    w_exc_code_nxt  = r_exc_code;
    w_exc_bd_nxt    = r_exc_bd;
    w_flush_nxt     = r_flush;
    w_exc_count_nxt = r_exc_count;

    case (r_state)
      S_NORMAL: begin
        if (w_take_exc) begin
          // Excepting instruction is squashed: ms fields keep the older bundle.
          w_state_nxt     = S_FLUSH;
          w_flush_cnt_nxt = CNT_W'(FLUSH_CYCLES - 1);
          w_flush_nxt     = 1'b1;
          w_ms_valid_nxt  = 1'b0;
          w_exc_req_nxt   = 1'b1;
          w_exc_epc_nxt   = ex_bd ? (ex_pc - XLEN'(4)) : ex_pc;
          w_exc_code_nxt  = EXC_CODE_OV;
          w_exc_bd_nxt    = ex_bd;
          if (r_exc_count != {EXCC_W{1'b1}}) begin
            w_exc_count_nxt = r_exc_count + EXCC_W'(1);
          end
        end else if (w_accept) begin
          w_ms_valid_nxt  = 1'b1;
          w_ms_pc_nxt     = ex_pc;
          w_ms_result_nxt = ex_result;
          w_ms_dest_nxt   = ex_dest;
          w_ms_wen_nxt    = ex_wen && (ex_dest != 5'd0);
        end else if (wb_allowin) begin
          w_ms_valid_nxt  = 1'b0;
        end
      end
      S_FLUSH: begin
        if (r_flush_cnt == '0) begin
          w_state_nxt = S_NORMAL;
          w_flush_nxt = 1'b0;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - CNT_W'(1);
        end
        if (wb_allowin) begin
          w_ms_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_NORMAL;
        w_flush_nxt = 1'b0;
      end
    endcase
  end

  assign ex_allowin = w_allowin;
  assign ms_valid   = r_ms_valid;
  assign ms_pc      = r_ms_pc;
  assign ms_result  = r_ms_result;
  assign ms_dest    = r_ms_dest;
  assign ms_wen     = r_ms_wen;
  assign exc_req    = r_exc_req;
  assign exc_epc    = r_exc_epc;
  assign exc_code   = r_exc_code;
  assign exc_bd     = r_exc_bd;
  assign flush      = r_flush;
  assign exc_count  = r_exc_count;

endmodule

// File: tb/tb_mycpu_ex_commit.sv
// Bench for mycpu_ex_commit: two instances (flush length 2 and 3) share stimulus
// and are compared every cycle against a transaction-level reference model.
module tb_mycpu_ex_commit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_wen, ex_ov, ex_bd, wb_allowin;
  logic [31:0] ex_pc, ex_result;
  logic [4:0]  ex_dest;

  logic        d_allowin [2];
  logic        d_vld     [2];
  logic [31:0] d_pc      [2];
  logic [31:0] d_res     [2];
  logic [4:0]  d_dest    [2];
  logic        d_wen     [2];
  logic        d_req     [2];
  logic [31:0] d_epc     [2];
  logic [4:0]  d_code    [2];
  logic        d_bd      [2];
  logic        d_flush   [2];
  logic [15:0] d_cnt     [2];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit        vld;
    bit [31:0] pc, res;
    bit [4:0]  dest;
    bit        wen, req;
    bit [31:0] epc;
    bit [4:0]  code;
    bit        bd;
    int        flush_left;
    int        exc_cnt;
  } mdl_t;

  mdl_t m [2];
  int   fc [2] = '{2, 3};

  always #5 clk = ~clk;

  mycpu_ex_commit #(.FLUSH_CYCLES(2), .EXC_CODE_OV(5'h0C)) u_dut2 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_allowin(d_allowin[0]),
    .ex_pc(ex_pc), .ex_result(ex_result), .ex_dest(ex_dest), .ex_wen(ex_wen),
    .ex_ov(ex_ov), .ex_bd(ex_bd), .wb_allowin(wb_allowin),
    .ms_valid(d_vld[0]), .ms_pc(d_pc[0]), .ms_result(d_res[0]), .ms_dest(d_dest[0]),
    .ms_wen(d_wen[0]), .exc_req(d_req[0]), .exc_epc(d_epc[0]), .exc_code(d_code[0]),
    .exc_bd(d_bd[0]), .flush(d_flush[0]), .exc_count(d_cnt[0])
  );

  mycpu_ex_commit #(.FLUSH_CYCLES(3), .EXC_CODE_OV(5'h0C)) u_dut3 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_allowin(d_allowin[1]),
    .ex_pc(ex_pc), .ex_result(ex_result), .ex_dest(ex_dest), .ex_wen(ex_wen),
    .ex_ov(ex_ov), .ex_bd(ex_bd), .wb_allowin(wb_allowin),
    .ms_valid(d_vld[1]), .ms_pc(d_pc[1]), .ms_result(d_res[1]), .ms_dest(d_dest[1]),
    .ms_wen(d_wen[1]), .exc_req(d_req[1]), .exc_epc(d_epc[1]), .exc_code(d_code[1]),
    .exc_bd(d_bd[1]), .flush(d_flush[1]), .exc_count(d_cnt[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_allowin(int i);
    return (m[i].flush_left == 0) && (!m[i].vld || wb_allowin);
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 2; i++) begin
      m[i] = '{default: 0};
    end
  endtask

  // Behavioural step of one instance: what a single clock edge does to the stage.
  task automatic mdl_edge(int i);
    bit acc;
    acc = ex_valid && exp_allowin(i);
    m[i].req = 1'b0;
    if (m[i].flush_left > 0) m[i].flush_left--;
    if (acc && ex_ov) begin
      m[i].req        = 1'b1;
      m[i].epc        = ex_bd ? ex_pc - 32'd4 : ex_pc;
      m[i].bd         = ex_bd;
      m[i].code       = 5'h0C;
      m[i].vld        = 1'b0;
      m[i].flush_left = fc[i];
      m[i].exc_cnt    = (m[i].exc_cnt < 65535) ? m[i].exc_cnt + 1 : 65535;
    end else if (acc) begin
      m[i].vld  = 1'b1;
      m[i].pc   = ex_pc;
      m[i].res  = ex_result;
      m[i].dest = ex_dest;
      m[i].wen  = ex_wen && (ex_dest != 5'd0);
    end else if (wb_allowin) begin
      m[i].vld = 1'b0;
    end
  endtask

  task automatic check_state(int i);
    string p;
    p = (i == 0) ? "f2" : "f3";
    check({p, ".ms_valid"},  32'(d_vld[i]),   32'(m[i].vld));
    check({p, ".ms_pc"},     d_pc[i],         m[i].pc);
    check({p, ".ms_result"}, d_res[i],        m[i].res);
    check({p, ".ms_dest"},   32'(d_dest[i]),  32'(m[i].dest));
    check({p, ".ms_wen"},    32'(d_wen[i]),   32'(m[i].wen));
    check({p, ".exc_req"},   32'(d_req[i]),   32'(m[i].req));
    check({p, ".exc_epc"},   d_epc[i],        m[i].epc);
    check({p, ".exc_code"},  32'(d_code[i]),  32'(m[i].code));
    check({p, ".exc_bd"},    32'(d_bd[i]),    32'(m[i].bd));
    check({p, ".flush"},     32'(d_flush[i]), 32'(m[i].flush_left > 0));
    check({p, ".exc_count"}, 32'(d_cnt[i]),   32'(m[i].exc_cnt));
  endtask

  // One clock: drive inputs, check combinational allowin, advance model, check outputs.
  task automatic step(input bit rst, input bit v, input bit [31:0] pc, input bit [31:0] res,
                      input bit [4:0] dest, input bit wen, input bit ov, input bit bd,
                      input bit wb);
    @(negedge clk);
    reset = rst; ex_valid = v; ex_pc = pc; ex_result = res; ex_dest = dest;
    ex_wen = wen; ex_ov = ov; ex_bd = bd; wb_allowin = wb;
    #1;
    check("f2.ex_allowin", 32'(d_allowin[0]), 32'(exp_allowin(0)));
    check("f3.ex_allowin", 32'(d_allowin[1]), 32'(exp_allowin(1)));
    @(posedge clk);
    if (rst) mdl_reset();
    else for (int i = 0; i < 2; i++) mdl_edge(i);
    #1;
    check_state(0);
    check_state(1);
  endtask

  task automatic idle(input int n, input bit wb);
    for (int k = 0; k < n; k++) step(0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0, wb);
  endtask

  initial begin
    reset = 1'b1; ex_valid = 0; ex_pc = '0; ex_result = '0; ex_dest = '0;
    ex_wen = 0; ex_ov = 0; ex_bd = 0; wb_allowin = 0;
    mdl_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Normal flow
    step(0, 1, 32'hBFC00010, 32'h12345678, 5'd8, 1, 0, 0, 1);
    idle(1, 1);

    // Backpressure
    step(0, 1, 32'h00000100, 32'hAAAA0001, 5'd3, 1, 0, 0, 1);
    for (int k = 0; k < 3; k++) step(0, 1, 32'h00000104, 32'hAAAA0002, 5'd4, 1, 0, 0, 0);
    step(0, 1, 32'h00000104, 32'hAAAA0002, 5'd4, 1, 0, 0, 1);

    // Overflow outside a delay slot, older instruction still in ms
    step(0, 1, 32'h80000020, 32'hDEADBEEF, 5'd9, 1, 1, 0, 1);
    idle(4, 1);

    // Overflow in delay slot; second ov presented during flush
    step(0, 1, 32'h80000024, 32'h0, 5'd10, 1, 1, 1, 1);
    for (int k = 0; k < 3; k++) step(0, 1, 32'h80000030, 32'h0, 5'd11, 1, 1, 0, 1);
    idle(2, 1);

    // Write gating
    step(0, 1, 32'h00000200, 32'h55555555, 5'd0, 1, 0, 0, 1);
    step(0, 1, 32'h00000204, 32'h66666666, 5'd7, 1, 1, 0, 1);
    idle(4, 1);

    // Reset in the second flush cycle
    step(0, 1, 32'h00000300, 32'h0, 5'd1, 1, 1, 0, 1);
    step(0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1);
    step(1, 1, 32'h00000304, 32'h0, 5'd1, 1, 0, 0, 1);
    idle(1, 1);

    // Saturation of exc_count
    @(negedge clk);
    force u_dut2.r_exc_count = 16'hFFFF;
    force u_dut3.r_exc_count = 16'hFFFF;
    #1;
    release u_dut2.r_exc_count;
    release u_dut3.r_exc_count;
    m[0].exc_cnt = 65535;
    m[1].exc_cnt = 65535;
    step(0, 1, 32'h00000400, 32'h0, 5'd2, 1, 1, 0, 1);
    idle(4, 1);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), $urandom, $urandom,
           5'($urandom_range(0, 31)), 1'($urandom), ($urandom_range(0, 7) == 0),
           1'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mycpu_ex_commit.md
Name: mycpu_ex_commit

Overview:
EX-to-MEM commit stage. It is the downstream consumer of the EX stage's result and overflow-exception flag. It holds the EX bundle in a pipeline register under a valid/allowin handshake, gates register write-back for excepting instructions, and raises the precise overflow exception (Ov) towards CP0. While the exception is taken, it drives a multi-cycle pipeline flush.

Parameters:
FLUSH_CYCLES, 2, number of cycles flush is held high after an exception; legal range 1..15.
EXC_CODE_OV, 5'h0C, ExcCode reported for an arithmetic overflow.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
ex_valid  input  1  EX stage holds a valid instruction.
ex_allowin  output  1  this stage accepts the EX bundle this cycle.
ex_pc  input  32  PC of the EX instruction.
ex_result  input  32  ALU result.
ex_dest  input  5  destination GPR.
ex_wen  input  1  instruction writes ex_dest.
ex_ov  input  1  overflow exception from the EX-stage checked add/sub.
ex_bd  input  1  instruction is in a branch delay slot.
wb_allowin  input  1  downstream stage accepts this cycle.
ms_valid  output  1  pipeline register holds a valid instruction.
ms_pc  output  32  registered PC.
ms_result  output  32  registered result.
ms_dest  output  5  registered destination.
ms_wen  output  1  registered, gated write enable.
exc_req  output  1  one-cycle exception request to CP0.
exc_epc  output  32  EPC for exc_req.
exc_code  output  5  ExcCode for exc_req.
exc_bd  output  1  BD bit for exc_req.
flush  output  1  squash all younger stages.
exc_count  output  16  saturating count of Ov exceptions taken.

Behaviour:
- Reset values: all outputs 0; state NORMAL; flush counter 0; exc_count 0.
- States:
  - NORMAL.
  - FLUSH: holds a 4-bit down-counter.
- ex_allowin is combinational: (state==NORMAL) && (!ms_valid || wb_allowin).
- Accept occurs when ex_valid && ex_allowin.
- On an accept with ex_ov=0:
  - next cycle ms_valid=1;
  - ms_pc, ms_result and ms_dest are loaded from the EX bundle;
  - ms_wen = ex_wen && (ex_dest != 0).
- On an accept with ex_ov=1, next cycle:
  - ms_valid=0; the excepting instruction is squashed and never reaches write-back, and no other ms_* field is updated.
  - exc_req=1 for exactly one cycle.
  - exc_epc = ex_bd ? ex_pc-4 (mod 2^32) : ex_pc.
  - exc_bd=ex_bd.
  - exc_code=EXC_CODE_OV.
  - flush=1.
  - State goes to FLUSH with counter=FLUSH_CYCLES-1.
  - exc_count increments, saturating at 16'hFFFF.
- No accept and wb_allowin=1: ms_valid clears to 0.
- Hold: ms_valid=1 and wb_allowin=0 → all ms_* hold unchanged and ex_allowin=0.
- FLUSH state:
  - flush=1 and ex_allowin=0; ex_valid is ignored (the flushed EX instruction is dropped by upstream).
  - Counter decrements each cycle.
  - When counter==0, next state is NORMAL and flush=0.
  - Total flush high time is exactly FLUSH_CYCLES cycles.
- exc_epc, exc_code and exc_bd hold their last values after exc_req drops; they are valid only while exc_req=1.
- Consecutive exceptions cannot overlap, because allowin=0 throughout FLUSH.
- An older instruction in ms moves to write-back in the same cycle the excepting instruction is accepted, because accept implies !ms_valid || wb_allowin. Older instructions are never squashed.
- Reset has priority over everything, including mid-FLUSH and a held ms bundle: one cycle later all state is at reset values.
- No combinational path exists from ex_* to any ms_*/exc_* output; the only combinational output is ex_allowin, derived from state, ms_valid and wb_allowin.

Test Plan:
1. Normal flow: ex_valid=1, pc=0xBFC00010, result=0x12345678, dest=8, wen=1, ov=0, wb_allowin=1.
   → next cycle ms_valid=1, ms_result=0x12345678, ms_wen=1; exc_req=0.
2. Backpressure: ms holds pc=0x100, wb_allowin=0 for 3 cycles, ex_valid=1 with pc=0x104.
   → ex_allowin=0 for 3 cycles, ms_pc stays 0x100; the cycle wb_allowin=1, pc=0x104 is accepted.
3. Overflow, no delay slot: ex_pc=0x80000020, ov=1, bd=0.
   → next cycle exc_req=1 for one cycle, exc_epc=0x80000020, exc_code=0x0C, ms_valid=0.
   → flush high 2 cycles; ex_allowin=0 during FLUSH; exc_count=1.
4. Overflow in delay slot: ex_pc=0x80000024, bd=1, FLUSH_CYCLES=3.
   → exc_epc=0x80000020, exc_bd=1, flush high exactly 3 cycles.
   → a second ov instruction is presented during FLUSH and is not accepted.
5. Write gating: ex_wen=1, dest=0, ov=0 → ms_wen=0. ex_ov=1 with wen=1 → no ms update, ms_wen unchanged.
6. Reset mid-FLUSH: assert reset in the 2nd flush cycle.
   → next cycle flush=0, ms_valid=0, exc_count=0, ex_allowin=1.
   → exc_count saturation: force 0xFFFF, take one more Ov → remains 0xFFFF.
